// File: rtl/npu_pkg.sv
// Shared definitions for the NPU matrix-multiply datapath.
// Holds the default grid dimension and operand/accumulator widths used by the
// systolic array and its processing elements, plus the matching scalar types.
package npu_pkg;

    localparam int NPU_ARRAY_SIZE = 4;
    localparam int NPU_DATA_WIDTH = 8;
    localparam int NPU_ACC_WIDTH  = 32;

    typedef logic signed [NPU_DATA_WIDTH-1:0] operand_t;
    typedef logic signed [NPU_ACC_WIDTH-1:0]  acc_t;

endpackage

// File: rtl/npu_pe.sv
// One processing element of the output-stationary systolic array.
// The activation and weight pass through one register stage each on their way
// to the right and downward neighbours, while the signed product of the
// incoming pair is accumulated locally.
//
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   en         : 1 = shift operands and accumulate, 0 = hold everything
//   acc_clr    : load the current product instead of adding it
//   i_a, i_b   : incoming activation (from the left) and weight (from above)
//   o_a, o_b   : registered activation / weight for the neighbours
//   o_acc      : registered accumulator
module npu_pe
    import npu_pkg::*;
#(
    parameter int DATA_WIDTH = NPU_DATA_WIDTH,
    parameter int ACC_WIDTH  = NPU_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  acc_clr,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [DATA_WIDTH-1:0] o_a,
    output logic [DATA_WIDTH-1:0] o_b,
    output logic [ACC_WIDTH-1:0]  o_acc
);

    logic [DATA_WIDTH-1:0]          r_a;
    logic [DATA_WIDTH-1:0]          r_b;
    logic [ACC_WIDTH-1:0]           r_acc;
    logic signed [2*DATA_WIDTH-1:0] w_aExt;
    logic signed [2*DATA_WIDTH-1:0] w_bExt;
    logic signed [2*DATA_WIDTH-1:0] w_product;
    logic [ACC_WIDTH-1:0]           w_productExt;

    // Both operands are widened to the full product width first so the
    // multiply is exact; the low 2*DATA_WIDTH bits then hold the true signed
    // product, which is sign-extended to the accumulator width.
    assign w_aExt       = (2*DATA_WIDTH)'($signed(i_a));
    assign w_bExt       = (2*DATA_WIDTH)'($signed(i_b));
    assign w_product    = w_aExt * w_bExt;
    assign w_productExt = ACC_WIDTH'(w_product);

    // acc_clr loads rather than zeroes so a new tile can start on the very
    // cycle its first product arrives. The accumulator wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
        end else if (en) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_acc <= acc_clr ? w_productExt : (r_acc + w_productExt);
        end
    end

    assign o_a   = r_a;
    assign o_b   = r_b;
    assign o_acc = r_acc;

endmodule

// File: rtl/npu_systolic_array.sv
// Output-stationary signed systolic array: an ARRAY_SIZE x ARRAY_SIZE grid of
// npu_pe instances. Activations enter on the left and move right one PE per
// cycle, weights enter on the top and move down one PE per cycle. Input skew
// and acc_clr alignment are the feeding controller's responsibility.
//
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   en         : advance enable for the whole grid
//   acc_clr    : clear-and-load all accumulators with the current products
//   row_in[i]  : left-edge activation for row i
//   col_in[j]  : top-edge weight for column j
//   array_out  : array_out[i*N+j] is the accumulator of PE(i,j)
module npu_systolic_array
    import npu_pkg::*;
#(
    parameter int ARRAY_SIZE = NPU_ARRAY_SIZE,
    parameter int DATA_WIDTH = NPU_DATA_WIDTH,
    parameter int ACC_WIDTH  = NPU_ACC_WIDTH
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic                                            en,
    input  logic                                            acc_clr,
    input  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0]           row_in,
    input  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0]           col_in,
    output logic [ARRAY_SIZE*ARRAY_SIZE-1:0][ACC_WIDTH-1:0] array_out
);

    // w_aLink[i][j] is the activation entering PE(i,j); column ARRAY_SIZE is
    // the spill-out of the right edge. w_bLink is the same idea for weights,
    // with row ARRAY_SIZE being the spill-out of the bottom edge.
    logic [DATA_WIDTH-1:0] w_aLink [ARRAY_SIZE][ARRAY_SIZE+1];
    logic [DATA_WIDTH-1:0] w_bLink [ARRAY_SIZE+1][ARRAY_SIZE];

    for (genvar e = 0; e < ARRAY_SIZE; e++) begin : gEdge
        assign w_aLink[e][0] = row_in[e];
        assign w_bLink[0][e] = col_in[e];
    end

    for (genvar i = 0; i < ARRAY_SIZE; i++) begin : gRow
        for (genvar j = 0; j < ARRAY_SIZE; j++) begin : gCol
            npu_pe #(
                .DATA_WIDTH (DATA_WIDTH),
                .ACC_WIDTH  (ACC_WIDTH)
            ) uPe (
                .clk     (clk),
                .rst_n   (rst_n),
                .en      (en),
                .acc_clr (acc_clr),
                .i_a     (w_aLink[i][j]),
                .i_b     (w_bLink[i][j]),
                .o_a     (w_aLink[i][j+1]),
                .o_b     (w_bLink[i+1][j]),
                .o_acc   (array_out[i*ARRAY_SIZE+j])
            );
        end
    end

endmodule

// File: tb/tb_npu_systolic_array.sv
// Randomized self-checking bench for npu_systolic_array. The reference model
// is the plain matrix definition: after e active edges, PE(i,j) holds the sum
// of A[i][k]*B[k][j] over every k whose meeting cycle k+i+j is below e.
module tb_npu_systolic_array;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int AW   = 32;
    localparam int KMAX = 16;

    logic                  clk;
    logic                  rst_n;
    logic                  en;
    logic                  accClr;
    logic [N-1:0][DW-1:0]  rowIn;
    logic [N-1:0][DW-1:0]  colIn;
    logic [N*N-1:0][AW-1:0] arrayOut;

    // Narrow single-PE instance used for the wrap-around check.
    logic                  wEn;
    logic                  wClr;
    logic [0:0][DW-1:0]    wRow;
    logic [0:0][DW-1:0]    wCol;
    logic [0:0][15:0]      wOut;

    int vectors  = 0;
    int failures = 0;

    int matA [N][KMAX];
    int matB [KMAX][N];
    int curK;

    npu_systolic_array #(
        .ARRAY_SIZE (N),
        .DATA_WIDTH (DW),
        .ACC_WIDTH  (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .acc_clr   (accClr),
        .row_in    (rowIn),
        .col_in    (colIn),
        .array_out (arrayOut)
    );

    npu_systolic_array #(
        .ARRAY_SIZE (1),
        .DATA_WIDTH (DW),
        .ACC_WIDTH  (16)
    ) dutWrap (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (wEn),
        .acc_clr   (wClr),
        .row_in    (wRow),
        .col_in    (wCol),
        .array_out (wOut)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)",
                     tag, $signed(observed), observed, $signed(expected), expected);
        end
    endtask

    function automatic int randByte();
        logic [7:0] v;
        v = 8'($urandom);
        return int'($signed(v));
    endfunction

    // Reference: sum of every product that has met in PE(i,j) within e edges.
    function automatic logic [31:0] expectedAcc(input int i, input int j, input int e);
        int s;
        s = 0;
        for (int k = 0; k < curK; k++)
            if (k + i + j < e)
                s += matA[i][k] * matB[k][j];
        return 32'(s);
    endfunction

    task automatic checkAll(input int e);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                checkOutput($sformatf("pe%0d%0d_e%0d", i, j, e), arrayOut[i*N+j], expectedAcc(i, j, e));
    endtask

    task automatic checkZero(input string tag);
        for (int p = 0; p < N*N; p++)
            checkOutput($sformatf("%s_pe%0d", tag, p), arrayOut[p], 32'd0);
    endtask

    task automatic randomMatrices(input int k);
        curK = k;
        for (int i = 0; i < N; i++)
            for (int kk = 0; kk < KMAX; kk++) begin
                matA[i][kk] = randByte();
                matB[kk][i] = randByte();
            end
    endtask

    // Drive one skewed operand cycle t of the current tile.
    task automatic applyStimulus(input int t, input logic clr);
        en     = 1'b1;
        accClr = clr;
        for (int i = 0; i < N; i++) begin
            rowIn[i] = (t - i >= 0 && t - i < curK) ? 8'(matA[i][t-i]) : 8'd0;
            colIn[i] = (t - i >= 0 && t - i < curK) ? 8'(matB[t-i][i]) : 8'd0;
        end
    endtask

    // Runs one tile, checking every accumulator after every edge. stallAt
    // inserts three en=0 cycles with junk inputs before operand cycle stallAt;
    // abortAt pulls reset asynchronously mid-tile and ends the tile there.
    task automatic runTile(input logic useClr, input int stallAt, input int abortAt);
        int total;
        total = curK + 2*N - 2;
        for (int t = 0; t < total; t++) begin
            if (t == abortAt) begin
                #2 rst_n = 1'b0;
                #1 checkZero("asyncReset");
                @(negedge clk);
                rst_n = 1'b1;
                en    = 1'b0;
                return;
            end
            if (t == stallAt) begin
                for (int s = 0; s < 3; s++) begin
                    en     = 1'b0;
                    accClr = 1'($urandom);
                    rowIn  = {N{8'($urandom | 1)}};
                    colIn  = {N{8'($urandom | 1)}};
                    @(posedge clk);
                    #1 checkAll(t);
                end
            end
            applyStimulus(t, useClr && (t == 0));
            @(posedge clk);
            #1 checkAll(t + 1);
        end
        en     = 1'b0;
        accClr = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b0;
        en     = 1'b0;
        accClr = 1'b0;
        rowIn  = '0;
        colIn  = '0;
        wEn    = 1'b0;
        wClr   = 1'b0;
        wRow   = '0;
        wCol   = '0;
        curK   = 0;

        #12 checkZero("reset");
        checkOutput("wrapReset", 32'(wOut[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Wrap: two -128*-128 products in a 16-bit accumulator.
        wEn  = 1'b1;
        wClr = 1'b1;
        wRow[0] = 8'h80;
        wCol[0] = 8'h80;
        @(posedge clk);
        #1 checkOutput("wrapFirst", 32'(wOut[0]), 32'd16384);
        wClr = 1'b0;
        @(posedge clk);
        #1 checkOutput("wrapSecond", 32'(wOut[0]), 32'h0000_8000);
        wEn = 1'b0;

        // Identity times 1..16, back-to-back into the following tiles.
        curK = 4;
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 4; k++) begin
                matA[i][k] = (i == k) ? 1 : 0;
                matB[k][i] = k * 4 + i + 1;
            end
        runTile(1'b1, -1, -1);
        for (int p = 0; p < N*N; p++)
            checkOutput($sformatf("identity%0d", p), arrayOut[p], 32'(p + 1));

        // Signed extremes at PE(0,0): -128*-128 then -128*127.
        randomMatrices(2);
        matA[0][0] = -128;
        matA[0][1] = -128;
        matB[0][0] = -128;
        matB[1][0] = 127;
        runTile(1'b1, -1, -1);
        checkOutput("signedExtremes", arrayOut[0], 32'd128);

        // Clear-and-load: 50 accumulated, then a new tile starting with 3*4.
        randomMatrices(2);
        matA[0][0] = 5;
        matA[0][1] = 5;
        matB[0][0] = 5;
        matB[1][0] = 5;
        runTile(1'b1, -1, -1);
        checkOutput("clearLoadBefore", arrayOut[0], 32'd50);
        randomMatrices(1);
        matA[0][0] = 3;
        matB[0][0] = 4;
        runTile(1'b1, -1, -1);
        checkOutput("clearLoadAfter", arrayOut[0], 32'd12);

        // Asynchronous reset mid-stream, then a fresh tile with no acc_clr.
        randomMatrices(6);
        runTile(1'b1, -1, 3);
        randomMatrices(5);
        runTile(1'b0, -1, -1);

        // Stall in the middle of a fixed tile.
        randomMatrices(4);
        runTile(1'b1, 4, -1);

        // Random tiles, every other one stalled at a random point.
        for (int n = 0; n < 8; n++) begin
            randomMatrices(int'($urandom_range(1, 10)));
            runTile(1'b1, (n % 2 == 1) ? int'($urandom_range(0, curK + 2*N - 3)) : -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, failures);
        $finish;
    end

endmodule
